spi_ecc_rx: RTL and testbench

//  Receive end of the error-correcting SPI link. Samples the raw sclk/mosi/ss wires in the

---
 rtl/spi_ecc_rx_pkg.sv | 22 ++
 rtl/spi_ecc_rx_if.sv | 27 ++
 rtl/spi_ecc_rx_hamming15_11_dec.sv | 40 ++++
 rtl/spi_ecc_rx.sv | 185 ++++++++++++++++++
 tb/tb_spi_ecc_rx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ecc_rx_pkg.sv
// spi_ecc_rx_pkg
//   Shared definitions for the error-correcting SPI link: word/codeword widths,
//   Hamming(15,11) data bit placement and the receive FSM state encoding.
//   Parity bits sit at the power-of-two positions 1, 2, 4 and 8.
//   The data bits fill the remaining positions in ascending order.
package spi_ecc_rx_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;
  localparam int SYN_W  = 4;

  // Codeword position (1-based) carrying data bit d[i]
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DECODE  = 2'd2,
    ST_WAIT_SS = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spi_ecc_rx_if.sv
// spi_ecc_rx_if
//   Consumer-side bus of the SPI ECC receiver.
//   master : the receiver. It drives data_out, valid, err, frame_err, overrun and busy,
//            and reads ready.
//   slave  : the consumer. It reads the word and the status signals, and drives ready.
interface spi_ecc_rx_if;
  import spi_ecc_rx_pkg::*;

  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              ready;
  logic              err;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    output data_out, valid, err, frame_err, overrun, busy,
    input  ready
  );

  modport slave (
    input  data_out, valid, err, frame_err, overrun, busy,
    output ready
  );

endinterface

// File: rtl/spi_ecc_rx_hamming15_11_dec.sv
// hamming15_11_dec
//   Purely combinational Hamming(15,11) decoder.
//   code[15:1] : received codeword, indexed by codeword position
//   data[10:0] : corrected data word (d0 taken from position 3)
//   syndrome   : XOR of the positions of all set bits; 0 means clean
//   A nonzero syndrome names the single flipped position, and that bit is inverted.
//   Two flipped bits produce a wrong but plausible syndrome and are miscorrected.
module hamming15_11_dec
  import spi_ecc_rx_pkg::*;
(
  input  logic [CODE_W:1]   code,
  output logic [DATA_W-1:0] data,
  output logic [SYN_W-1:0]  syndrome
);

  logic [CODE_W:1] corrected;

  always_comb begin
    syndrome = '0;
    for (int p = 1; p <= CODE_W; p++) begin
      if (code[p]) syndrome = syndrome ^ p[SYN_W-1:0];
    end
  end

  // A syndrome of zero matches no position, so a clean word passes through unchanged.
  always_comb begin
    corrected = code;
    for (int p = 1; p <= CODE_W; p++) begin
      if (syndrome == p[SYN_W-1:0]) corrected[p] = ~code[p];
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = corrected[DATA_POS[i]];
    end
  end

endmodule

// File: rtl/spi_ecc_rx.sv
// spi_ecc_rx
//   Receive end of the error-correcting SPI link. Oversamples sclk/mosi/ss in the clk
//   domain, shifts one Hamming(15,11) codeword per ss-low window (position 15 first),
//   corrects single-bit errors and offers the 11-bit word on a one-entry valid/ready buffer.
//   Ports:
//     clk        : system clock (rising edge)
//     reset      : asynchronous, active-low
//     sclk/mosi  : serial clock and data from the master (asynchronous to clk)
//     ss         : active-low slave select, one frame per low window
//     bus        : spi_ecc_rx_if.master carrying data_out, valid, ready, err,
//                  frame_err, overrun and busy
//   Parameter SYNC_STAGES (2..4) sets the depth of each input synchronizer.
module spi_ecc_rx
  import spi_ecc_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sclk,
  input  logic         mosi,
  input  logic         ss,
  spi_ecc_rx_if.master bus
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sclk_dly;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   sclk_rise;

  rx_state_t              state;
  rx_state_t              state_next;
  logic [3:0]             bit_cnt;
  logic [CODE_W:1]        shift_reg;

  logic                   shift_en;
  logic                   frame_abort;
  logic                   load_buf;
  logic                   drop_word;
  logic                   busy_c;

  logic [DATA_W-1:0]      dec_data;
  logic [SYN_W-1:0]       dec_syn;

  logic [DATA_W-1:0]      data_q;
  logic                   valid_q;
  logic                   err_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  // ss resets high so that a reset does not look like a new frame starting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_dly  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_dly  <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // SHIFT always leaves on the 15th bit, so an ss release seen while in SHIFT is a short frame.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!ss_s) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ss_s) begin
          state_next = ST_IDLE;
        end else if (sclk_rise && bit_cnt == 4'(CODE_W - 1)) begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = ST_WAIT_SS;
      end
      ST_WAIT_SS: begin
        if (ss_s) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // During DECODE, the buffer accepts the new word if it is empty, or if its current word
  // is taken in the same cycle. Otherwise the new word is dropped.
  always_comb begin
    shift_en    = 1'b0;
    frame_abort = 1'b0;
    load_buf    = 1'b0;
    drop_word   = 1'b0;
    busy_c      = 1'b0;
    case (state)
      ST_SHIFT: begin
        busy_c = 1'b1;
        if (ss_s) begin
          frame_abort = 1'b1;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      ST_DECODE: begin
        busy_c = 1'b1;
        if (!valid_q || bus.ready) begin
          load_buf = 1'b1;
        end else begin
          drop_word = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (state == ST_IDLE) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt   <= bit_cnt + 4'd1;
      shift_reg <= {shift_reg[CODE_W-1:1], mosi_s};
    end
  end

  hamming15_11_dec u_dec (
    .code     (shift_reg),
    .data     (dec_data),
    .syndrome (dec_syn)
  );

  // data_out and err keep their last value after the consumer takes the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_abort;
      overrun_q   <= drop_word;
      if (load_buf) begin
        data_q  <= dec_data;
        err_q   <= |dec_syn;
        valid_q <= 1'b1;
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_spi_ecc_rx.sv
// tb_spi_ecc_rx
//   Self-checking bench for spi_ecc_rx. Codewords come from a reference Hamming encoder,
//   built from the parity-coverage rule. A single position may be flipped on the way.
//   Words the consumer takes are queued by a monitor and compared with the original data.
//   Pulse outputs are counted and compared with the expected number of events.
module tb_spi_ecc_rx;

  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic reset;
  logic sclk;
  logic mosi;
  logic ss;

  spi_ecc_rx_if rx_bus ();

  spi_ecc_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .sclk  (sclk),
    .mosi  (mosi),
    .ss    (ss),
    .bus   (rx_bus)
  );

  always #5 clk = ~clk;

  int num_compared   = 0;
  int num_mismatched = 0;
  int frame_err_cycles = 0;
  int overrun_cycles   = 0;
  int exp_frame_err    = 0;
  int exp_overrun      = 0;
  logic [11:0] acc_q [$];

  // Inputs change just after posedge, so negedge sees the values the next posedge will use.
  always @(negedge clk) begin
    if (rx_bus.frame_err) frame_err_cycles++;
    if (rx_bus.overrun) overrun_cycles++;
    if (rx_bus.valid && rx_bus.ready) acc_q.push_back({rx_bus.err, rx_bus.data_out});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:1] encode(input logic [10:0] d);
    logic [15:1] c;
    int          k;
    int          pp;
    logic        par;
    c = '0;
    k = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      pp  = 1 << b;
      par = 1'b0;
      for (int p = 1; p <= 15; p++) begin
        if ((p & pp) != 0 && p != pp) par = par ^ c[p];
      end
      c[pp] = par;
    end
    return c;
  endfunction

  // Send nbits of a codeword, position 15 first. mosi changes while sclk is low.
  // With ready_in_decode set, ready is pulsed exactly in the cycle the receiver decodes.
  // That cycle follows the synchronizer delay plus one cycle for edge detection.
  task automatic apply_stimulus(input logic [15:1] code, input int nbits,
                                input bit raise_ss, input bit ready_in_decode);
    ss = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < nbits; i++) begin
      mosi = code[15 - i];
      repeat (HALF) tick();
      sclk = 1'b1;
      if (ready_in_decode && i == nbits - 1) begin
        repeat (SYNC + 1) tick();
        rx_bus.ready = 1'b1;
        tick();
        rx_bus.ready = 1'b0;
        repeat (HALF - SYNC - 2) tick();
      end else begin
        repeat (HALF) tick();
      end
      if (i == 4) check_output("busy_shift", 32'(rx_bus.busy), 32'd1);
      sclk = 1'b0;
    end
    repeat (HALF) tick();
    if (raise_ss) begin
      ss = 1'b1;
      repeat (10) tick();
      check_output("busy_idle", 32'(rx_bus.busy), 32'd0);
    end
  endtask

  task automatic expect_word(input string tag, input logic [10:0] d, input logic e);
    logic [11:0] w;
    check_output({tag, "_count"}, 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) begin
      w = acc_q.pop_front();
      check_output({tag, "_data"}, 32'(w[10:0]), 32'(d));
      check_output({tag, "_err"}, 32'(w[11]), 32'(e));
    end
    acc_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_data"}, 32'(rx_bus.data_out), 32'd0);
    check_output({tag, "_valid"}, 32'(rx_bus.valid), 32'd0);
    check_output({tag, "_err"}, 32'(rx_bus.err), 32'd0);
    check_output({tag, "_frame_err"}, 32'(rx_bus.frame_err), 32'd0);
    check_output({tag, "_overrun"}, 32'(rx_bus.overrun), 32'd0);
    check_output({tag, "_busy"}, 32'(rx_bus.busy), 32'd0);
  endtask

  initial begin
    logic [15:1] c;
    logic [10:0] d;
    int          pos;
    bit          hold;

    reset = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ss    = 1'b1;
    rx_bus.ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (4) tick();

    apply_stimulus(encode(11'h5A3), 15, 1'b1, 1'b0);
    expect_word("clean", 11'h5A3, 1'b0);
    check_output("clean_hold_data", 32'(rx_bus.data_out), 32'h5A3);
    check_output("clean_valid_low", 32'(rx_bus.valid), 32'd0);

    c = encode(11'h5A3);
    c[6] = ~c[6];
    apply_stimulus(c, 15, 1'b1, 1'b0);
    expect_word("flip6", 11'h5A3, 1'b1);

    c = encode(11'h7FF);
    c[1] = ~c[1];
    apply_stimulus(c, 15, 1'b1, 1'b0);
    expect_word("flip_parity1", 11'h7FF, 1'b1);

    apply_stimulus(encode(11'h123), 7, 1'b1, 1'b0);
    exp_frame_err++;
    check_output("trunc_valid", 32'(rx_bus.valid), 32'd0);
    check_output("trunc_no_word", 32'(acc_q.size()), 32'd0);
    check_output("trunc_frame_err", 32'(frame_err_cycles), 32'(exp_frame_err));
    apply_stimulus(encode(11'h456), 15, 1'b1, 1'b0);
    expect_word("after_trunc", 11'h456, 1'b0);

    for (int n = 0; n < 24; n++) begin
      d    = 11'($urandom);
      pos  = $urandom_range(0, 15);
      hold = 1'($urandom_range(0, 1));
      c    = encode(d);
      if (pos != 0) c[pos] = ~c[pos];
      rx_bus.ready = ~hold;
      apply_stimulus(c, 15, 1'b1, 1'b0);
      if (hold) begin
        check_output("rand_hold_valid", 32'(rx_bus.valid), 32'd1);
        check_output("rand_hold_data", 32'(rx_bus.data_out), 32'(d));
        check_output("rand_hold_err", 32'(rx_bus.err), 32'(pos != 0));
        rx_bus.ready = 1'b1;
        tick();
      end
      expect_word("rand", d, pos != 0);
    end

    rx_bus.ready = 1'b0;
    apply_stimulus(encode(11'h001), 15, 1'b1, 1'b0);
    check_output("ovr_first_valid", 32'(rx_bus.valid), 32'd1);
    check_output("ovr_first_data", 32'(rx_bus.data_out), 32'h001);
    apply_stimulus(encode(11'h002), 15, 1'b1, 1'b0);
    exp_overrun++;
    check_output("ovr_pulse", 32'(overrun_cycles), 32'(exp_overrun));
    check_output("ovr_held_data", 32'(rx_bus.data_out), 32'h001);
    check_output("ovr_held_valid", 32'(rx_bus.valid), 32'd1);
    rx_bus.ready = 1'b1;
    tick();
    rx_bus.ready = 1'b0;
    tick();
    expect_word("ovr_drain", 11'h001, 1'b0);
    check_output("ovr_drained_valid", 32'(rx_bus.valid), 32'd0);

    apply_stimulus(encode(11'h001), 15, 1'b1, 1'b0);
    apply_stimulus(encode(11'h002), 15, 1'b1, 1'b1);
    expect_word("take_old", 11'h001, 1'b0);
    check_output("take_new_data", 32'(rx_bus.data_out), 32'h002);
    check_output("take_new_valid", 32'(rx_bus.valid), 32'd1);
    check_output("take_no_overrun", 32'(overrun_cycles), 32'(exp_overrun));
    rx_bus.ready = 1'b1;
    tick();
    expect_word("take_new", 11'h002, 1'b0);

    apply_stimulus(encode(11'h3C5), 9, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_reset_outputs("midreset");
    ss   = 1'b1;
    sclk = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
    apply_stimulus(encode(11'h3C5), 15, 1'b1, 1'b0);
    expect_word("post_reset", 11'h3C5, 1'b0);

    check_output("total_frame_err", 32'(frame_err_cycles), 32'(exp_frame_err));
    check_output("total_overrun", 32'(overrun_cycles), 32'(exp_overrun));
    check_output("leftover_words", 32'(acc_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
